// File: rtl/linescan_camera_ctrl.sv
// rtl/linescan_camera_ctrl.sv - line-scan camera and serial ADC sequencer
//
// Purpose: drives the line-scan camera SI/CLK pins and, for every pixel, one ADC
// conversion plus SPI read-back. Each sample is streamed out as a one-cycle strobe
// with its pixel index. A line is SI pulse, NUM_PIXELS sampled pixels, one tail clock,
// then an optional exposure gap before the next line.
//
// Optional feature: define LINESCAN_STATS_EN to get per-line min/max of pix_data on
// line_min/line_max (updated in the line_done cycle). Without it both are tied to 0.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   enable                level, 1 = scan lines back to back
//   exposure[23:0]        idle cycles between lines, sampled at line start
//   adc_cfg[5:0]          ADC config word shifted out on adc_sdi_pin, sampled at line start
//   camera_clk_pin        camera pixel clock
//   camera_si_pin         camera start-integration pulse
//   adc_convst_pin        ADC convert start
//   adc_sck_pin           ADC SPI clock (idle low)
//   adc_sdi_pin           ADC config data, MSB first
//   adc_sdo_pin           ADC result data, MSB first
//   pix_valid             one-cycle strobe qualifying pix_data/pix_index
//   pix_data, pix_index   pixel sample and its number
//   line_done             one-cycle strobe with the last pixel of a line
//   busy                  high while a line (or its exposure gap) is in progress
//   line_min, line_max    per-line statistics
module linescan_camera_ctrl #(
   parameter int NUM_PIXELS  = 128,
   parameter int CLK_HALF    = 25,
   parameter int CONV_CYCLES = 80,
   parameter int SCK_HALF    = 2,
   parameter int ADC_BITS    = 12,
   parameter int IDX_W       = $clog2(NUM_PIXELS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [23:0]         exposure,
   input  logic [5:0]          adc_cfg,
   output logic                camera_clk_pin,
   output logic                camera_si_pin,
   output logic                adc_convst_pin,
   output logic                adc_sck_pin,
   output logic                adc_sdi_pin,
   input  logic                adc_sdo_pin,
   output logic                pix_valid,
   output logic [ADC_BITS-1:0] pix_data,
   output logic [IDX_W-1:0]    pix_index,
   output logic                line_done,
   output logic                busy,
   output logic [ADC_BITS-1:0] line_min,
   output logic [ADC_BITS-1:0] line_max
);

   localparam int BIT_W = $clog2(ADC_BITS);
   localparam logic [23:0] HALF      = 24'(CLK_HALF);
   localparam logic [23:0] HALF_LAST = 24'(CLK_HALF - 1);
   localparam logic [23:0] TAIL_LAST = 24'(2 * CLK_HALF - 1);
   localparam logic [23:0] CONV_LAST = 24'(CONV_CYCLES - 1);
   localparam logic [23:0] SCK_HI    = 24'(SCK_HALF);
   localparam logic [23:0] SCK_LAST  = 24'(2 * SCK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SI_HIGH, S_SI_CLK, S_CONV, S_CONV_WAIT, S_SHIFT,
      S_PIX_OUT, S_CLK_HI, S_CLK_LO, S_TAIL_CLK, S_EXPOSE
   } state_t;

   state_t              state_q, state_d;
   logic [23:0]         cnt_q, cnt_d;
   logic [BIT_W-1:0]    sbit_q, sbit_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [23:0]         exp_q, exp_d;
   logic [5:0]          cfg_q, cfg_d;
   logic [ADC_BITS-1:0] shift_q;
   logic [ADC_BITS-1:0] pix_data_q;
   logic [IDX_W-1:0]    pix_index_q;
   logic camera_clk_q, camera_clk_d, si_q, si_d, convst_q, convst_d;
   logic adc_sck_q, adc_sck_d, adc_sdi_q, adc_sdi_d;
   logic pix_valid_q, pix_valid_d, line_done_q, line_done_d, busy_q, busy_d;
   logic [15:0] cfg_word;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 24'd1;
      sbit_d  = sbit_q;
      idx_d   = idx_q;
      exp_d   = exp_q;
      cfg_d   = cfg_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) state_d = S_SI_HIGH;
         end
         S_SI_HIGH: if (cnt_q == HALF_LAST) begin state_d = S_SI_CLK; cnt_d = '0; end
         S_SI_CLK:  if (cnt_q == HALF_LAST) begin state_d = S_CONV;   cnt_d = '0; end
         // counter keeps running into CONV_WAIT so the conversion time is measured from convst rise
         S_CONV:      if (cnt_q == 24'd1) state_d = S_CONV_WAIT;
         S_CONV_WAIT: if (cnt_q >= CONV_LAST) begin state_d = S_SHIFT; cnt_d = '0; end
         // cnt is the phase inside one sck period, sbit the period number
         S_SHIFT: if (cnt_q == SCK_LAST) begin
            cnt_d = '0;
            if (sbit_q == BIT_LAST) begin
               state_d = S_PIX_OUT;
               sbit_d  = '0;
            end else begin
               sbit_d = sbit_q + BIT_W'(1);
            end
         end
         // the camera already shows pixel 0 after the SI clock, so the last pixel skips
         // straight to the tail clock: NUM_PIXELS clocks plus one tail clock per line
         S_PIX_OUT: begin
            cnt_d   = '0;
            state_d = (idx_q == IDX_LAST) ? S_TAIL_CLK : S_CLK_HI;
         end
         S_CLK_HI: if (cnt_q == HALF_LAST) begin state_d = S_CLK_LO; cnt_d = '0; end
         S_CLK_LO: if (cnt_q == HALF_LAST) begin
            state_d = S_CONV;
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
         end
         S_TAIL_CLK: if (cnt_q == TAIL_LAST) begin
            cnt_d = '0;
            if (!enable)          state_d = S_IDLE;
            else if (exp_q == '0) state_d = S_SI_HIGH;
            else                  state_d = S_EXPOSE;
         end
         S_EXPOSE: if (cnt_q == exp_q - 24'd1) begin
            cnt_d   = '0;
            state_d = enable ? S_SI_HIGH : S_IDLE;
         end
         default: begin state_d = S_IDLE; cnt_d = '0; end
      endcase
      // line start: sample the line settings and rewind the pixel counter
      if (state_d == S_SI_HIGH && state_q != S_SI_HIGH) begin
         exp_d = exposure;
         cfg_d = adc_cfg;
         idx_d = '0;
      end
   end

   // Pin values are decoded from the next state and registered, so every pin is a flop
   always_comb begin
      camera_clk_d = 1'b0;
      si_d         = 1'b0;
      convst_d     = 1'b0;
      adc_sck_d    = 1'b0;
      adc_sdi_d    = 1'b0;
      pix_valid_d  = 1'b0;
      line_done_d  = 1'b0;
      busy_d       = (state_d != S_IDLE);
      cfg_word     = {cfg_d, 10'b0};
      case (state_d)
         S_SI_HIGH: si_d = 1'b1;
         S_SI_CLK:  begin si_d = 1'b1; camera_clk_d = 1'b1; end
         S_CONV:    convst_d = 1'b1;
         S_SHIFT: begin
            adc_sck_d = (cnt_d >= SCK_HI);
            adc_sdi_d = cfg_word[4'd15 - 4'(sbit_d)];
         end
         S_PIX_OUT: begin
            pix_valid_d = 1'b1;
            line_done_d = (idx_d == IDX_LAST);
         end
         S_CLK_HI:   camera_clk_d = 1'b1;
         S_TAIL_CLK: camera_clk_d = (cnt_d < HALF);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sbit_q       <= '0;
         idx_q        <= '0;
         exp_q        <= '0;
         cfg_q        <= '0;
         shift_q      <= '0;
         pix_data_q   <= '0;
         pix_index_q  <= '0;
         camera_clk_q <= 1'b0;
         si_q         <= 1'b0;
         convst_q     <= 1'b0;
         adc_sck_q    <= 1'b0;
         adc_sdi_q    <= 1'b0;
         pix_valid_q  <= 1'b0;
         line_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sbit_q       <= sbit_d;
         idx_q        <= idx_d;
         exp_q        <= exp_d;
         cfg_q        <= cfg_d;
         camera_clk_q <= camera_clk_d;
         si_q         <= si_d;
         convst_q     <= convst_d;
         adc_sck_q    <= adc_sck_d;
         adc_sdi_q    <= adc_sdi_d;
         pix_valid_q  <= pix_valid_d;
         line_done_q  <= line_done_d;
         busy_q       <= busy_d;
         // sample sdo on the same edge that raises the sck pin
         if (adc_sck_d && !adc_sck_q) shift_q <= {shift_q[ADC_BITS-2:0], adc_sdo_pin};
         if (state_d == S_PIX_OUT) begin
            pix_data_q  <= shift_q;
            pix_index_q <= idx_q;
         end
      end
   end

`ifdef LINESCAN_STATS_EN
   logic [ADC_BITS-1:0] run_min_q, run_max_q, min_q, max_q;
   logic [ADC_BITS-1:0] cur_min, cur_max, new_min, new_max;

   // pixel 0 restarts the running values
   always_comb begin
      cur_min = (idx_q == '0) ? shift_q : run_min_q;
      cur_max = (idx_q == '0) ? shift_q : run_max_q;
      new_min = (shift_q < cur_min) ? shift_q : cur_min;
      new_max = (shift_q > cur_max) ? shift_q : cur_max;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_min_q <= '0;
         run_max_q <= '0;
         min_q     <= '0;
         max_q     <= '0;
      end else if (state_d == S_PIX_OUT) begin
         run_min_q <= new_min;
         run_max_q <= new_max;
         if (idx_q == IDX_LAST) begin
            min_q <= new_min;
            max_q <= new_max;
         end
      end
   end

   assign line_min = min_q;
   assign line_max = max_q;
`else
   assign line_min = '0;
   assign line_max = '0;
`endif

   assign camera_clk_pin = camera_clk_q;
   assign camera_si_pin  = si_q;
   assign adc_convst_pin = convst_q;
   assign adc_sck_pin    = adc_sck_q;
   assign adc_sdi_pin    = adc_sdi_q;
   assign pix_valid      = pix_valid_q;
   assign pix_data       = pix_data_q;
   assign pix_index      = pix_index_q;
   assign line_done      = line_done_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_linescan_camera_ctrl.sv
// tb/tb_linescan_camera_ctrl.sv - self-checking bench for linescan_camera_ctrl
module tb_linescan_camera_ctrl;
   localparam int NP = 128;
   localparam int CH = 4;
   localparam int CC = 8;
   localparam int SH = 1;
   localparam int AB = 12;
   localparam int LIM = 30000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] exposure = '0;
   logic [5:0]  adc_cfg = '0;
   logic        adc_sdo_pin = 1'b0;
   logic        camera_clk_pin, camera_si_pin, adc_convst_pin, adc_sck_pin, adc_sdi_pin;
   logic        pix_valid, line_done, busy;
   logic [11:0] pix_data, line_min, line_max;
   logic [6:0]  pix_index;

   always #5 clk = ~clk;

   linescan_camera_ctrl #(
      .NUM_PIXELS(NP), .CLK_HALF(CH), .CONV_CYCLES(CC), .SCK_HALF(SH), .ADC_BITS(AB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .exposure(exposure), .adc_cfg(adc_cfg),
      .camera_clk_pin(camera_clk_pin), .camera_si_pin(camera_si_pin),
      .adc_convst_pin(adc_convst_pin), .adc_sck_pin(adc_sck_pin), .adc_sdi_pin(adc_sdi_pin),
      .adc_sdo_pin(adc_sdo_pin), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_index(pix_index), .line_done(line_done), .busy(busy),
      .line_min(line_min), .line_max(line_max)
   );

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;

   // ADC model: word per pixel of the current line
   logic [11:0] adc_word [NP];
   logic [11:0] got [NP];
   logic [11:0] sdi_log [NP];
   int          rise_log [NP];

   logic si_p = 1'b0, cam_p = 1'b0, cv_p = 1'b0, sck_p = 1'b0;
   int   adc_pix = -1, kbit = 12;
   logic [11:0] sdi_sh = '0;
   int   cam_rises = 0, si_rises = 0, prev_rises = 0, prev_si_rises = 0, cam_falls = 0;
   logic si_at_fall1 = 1'b1;
   int   si_rise_cnt = 0, t_si = 0;
   int   line_valid = 0, order_bad = 0, exp_next = 0, last_idx = -1;
   int   done_cnt = 0, done_idx = -1, t_done = 0, stray_done = 0;
   logic [11:0] done_min = '0, done_max = '0;

   always @(negedge clk) begin
      cyc++;
      if (camera_si_pin && !si_p) begin
         si_rise_cnt++;
         t_si = cyc;
         prev_rises = cam_rises;
         prev_si_rises = si_rises;
         cam_rises = 0;
         si_rises = 0;
         cam_falls = 0;
         adc_pix = -1;
         line_valid = 0;
         exp_next = 0;
         order_bad = 0;
      end
      if (camera_clk_pin && !cam_p) begin
         cam_rises++;
         if (camera_si_pin) si_rises++;
      end
      if (!camera_clk_pin && cam_p) begin
         if (cam_falls == 0) si_at_fall1 = camera_si_pin;
         cam_falls++;
      end
      if (adc_convst_pin && !cv_p) begin
         adc_pix++;
         kbit = 0;
         sdi_sh = '0;
      end
      if (adc_sck_pin && !sck_p) begin
         sdi_sh = {sdi_sh[10:0], adc_sdi_pin};
         kbit++;
         if (adc_pix >= 0 && adc_pix < NP) begin
            sdi_log[adc_pix] = sdi_sh;
            rise_log[adc_pix] = kbit;
         end
      end
      if (adc_pix >= 0 && adc_pix < NP && kbit < 12) adc_sdo_pin = adc_word[adc_pix][11-kbit];
      else adc_sdo_pin = 1'b0;
      if (pix_valid) begin
         line_valid++;
         if (int'(pix_index) != exp_next) order_bad++;
         got[pix_index] = pix_data;
         exp_next = int'(pix_index) + 1;
         last_idx = int'(pix_index);
         if (line_done) begin
            done_cnt++;
            done_idx = int'(pix_index);
            t_done = cyc;
            done_min = line_min;
            done_max = line_max;
         end
      end else if (line_done) begin
         stray_done++;
      end
      si_p = camera_si_pin;
      cam_p = camera_clk_pin;
      cv_p = adc_convst_pin;
      sck_p = adc_sck_pin;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic wait_done(input string tag, input int n0);
      int c = 0;
      while (done_cnt == n0 && c < LIM) begin tick(); c++; end
      chk(tag, done_cnt, n0 + 1);
   endtask

   task automatic wait_idx(input string tag, input int idx);
      int c = 0;
      while (last_idx != idx && c < LIM) begin tick(); c++; end
      chk(tag, last_idx, idx);
   endtask

   task automatic wait_si(input string tag, input int n0);
      int c = 0;
      while (si_rise_cnt == n0 && c < LIM) begin tick(); c++; end
      chk(tag, si_rise_cnt, n0 + 1);
   endtask

   task automatic check_line(input string tag, input logic [5:0] cfg);
      int bad_d = 0, bad_s = 0, bad_r = 0;
      logic [11:0] mn = 12'hFFF, mx = 12'h000;
      for (int i = 0; i < NP; i++) begin
         if (got[i] !== adc_word[i]) bad_d++;
         if (sdi_log[i] !== {cfg, 6'b0}) bad_s++;
         if (rise_log[i] != 12) bad_r++;
         if (adc_word[i] < mn) mn = adc_word[i];
         if (adc_word[i] > mx) mx = adc_word[i];
      end
`ifndef LINESCAN_STATS_EN
      mn = '0;
      mx = '0;
`endif
      chk({tag, ".data_errs"}, bad_d, 0);
      chk({tag, ".sdi_errs"}, bad_s, 0);
      chk({tag, ".sck_rise_errs"}, bad_r, 0);
      chk({tag, ".valid_count"}, line_valid, NP);
      chk({tag, ".order_errs"}, order_bad, 0);
      chk({tag, ".done_idx"}, done_idx, NP - 1);
      chk({tag, ".stray_done"}, stray_done, 0);
      chk({tag, ".line_min"}, done_min, mn);
      chk({tag, ".line_max"}, done_max, mx);
   endtask

   logic [5:0] cfg_b, cfg_c, cfg_e;
   int t_a, t_b, gap_a, gap_b, n0, c;

   initial begin
      tick(2);
      chk("reset.outputs", {camera_clk_pin, camera_si_pin, adc_convst_pin, adc_sck_pin,
          adc_sdi_pin, pix_valid, line_done, busy, pix_data, pix_index, line_min, line_max}, 0);
      reset_n = 1'b1;
      tick(20);
      chk("idle.busy", busy, 0);
      chk("idle.no_si", si_rise_cnt, 0);

      // Line A: ramp data, fixed config; settings changed mid-line for line B
      for (int i = 0; i < NP; i++) adc_word[i] = 12'(i * 16);
      adc_cfg = 6'b100010;
      exposure = 24'd0;
      enable = 1'b1;
      wait_idx("A.pix10", 10);
      cfg_b = 6'($urandom);
      exposure = 24'd1000;
      adc_cfg = cfg_b;
      wait_done("A.done", 0);
      t_a = t_done;
      check_line("A", 6'b100010);
      chk("A.si_low_at_first_fall", si_at_fall1, 0);
      for (int i = 0; i < NP; i++) adc_word[i] = 12'($urandom);
      wait_si("B.start", 1);
      gap_a = t_si - t_a;
      chk("A.cam_rises", prev_rises, NP + 1);
      chk("A.si_rises", prev_si_rises, 1);

      // Line B: random data, exposure 1000 latched at its start
      wait_idx("B.pix10", 10);
      cfg_c = 6'($urandom);
      exposure = 24'd0;
      adc_cfg = cfg_c;
      wait_done("B.done", 1);
      t_b = t_done;
      check_line("B", cfg_b);
      for (int i = 0; i < NP; i++) adc_word[i] = 12'h123;
      adc_word[10] = 12'h005;
      adc_word[90] = 12'hFFF;
      wait_si("C.start", 2);
      gap_b = t_si - t_b;
      chk("B.exposure_gap_delta", gap_b - gap_a, 1000);
      chk("B.cam_rises", prev_rises, NP + 1);
      chk("B.si_rises", prev_si_rises, 1);

      // Line C: enable dropped at pixel 40, line still completes
      wait_idx("C.pix40", 40);
      enable = 1'b0;
      wait_done("C.done", 2);
      check_line("C", cfg_c);
      c = 0;
      while (busy && c < 1000) begin tick(); c++; end
      chk("C.busy_low", busy, 0);
      chk("C.cam_rises", cam_rises, NP + 1);
      n0 = si_rise_cnt;
      tick(300);
      chk("C.no_new_si", si_rise_cnt, n0);
      chk("C.still_idle", busy, 0);

      // Line D: reset at pixel 60
      for (int i = 0; i < NP; i++) adc_word[i] = 12'($urandom);
      adc_cfg = 6'($urandom);
      exposure = 24'($urandom_range(0, 40));
      enable = 1'b1;
      wait_idx("D.pix60", 60);
      n0 = done_cnt;
      #1;
      reset_n = 1'b0;
      #1;
      chk("D.reset_pins", {camera_clk_pin, camera_si_pin, adc_convst_pin, adc_sck_pin,
          adc_sdi_pin, pix_valid, line_done, busy}, 0);
      enable = 1'b0;
      tick(5);
      reset_n = 1'b1;
      tick(50);
      chk("D.no_line_done", done_cnt, n0);
      chk("D.busy_after_reset", busy, 0);

      // Line E: fresh line after reset
      for (int i = 0; i < NP; i++) adc_word[i] = 12'($urandom);
      cfg_e = 6'($urandom);
      adc_cfg = cfg_e;
      exposure = 24'd0;
      enable = 1'b1;
      wait_done("E.done", n0);
      check_line("E", cfg_e);
      enable = 1'b0;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
